// File: rtl/data_c_pipe_latency_flex.sv
// Fixed-latency valid/ready pipeline for the data_c stream family.
// LAT register stages sit between the upstream slaver and the downstream master.
// The pipe has two stall behaviours:
//   MODE=0 (lockstep): the whole pipe freezes on backpressure and bubbles are preserved.
//   MODE=1 (elastic):  bubbles collapse under backpressure.
// It also provides a synchronous flush and an occupancy count that always equals popcount(v).
module data_c_pipe_latency_flex #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned DSIZE = 18,
  parameter int unsigned MODE  = 0,
  // Derived; LAT=0 still gets a 1-bit port (tied to zero) so the port is never zero-width.
  parameter int unsigned CSIZE = (LAT == 0) ? 1 : $clog2(LAT + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             flush,
  input  logic             slaver_valid,
  input  logic [DSIZE-1:0] slaver_data,
  output logic             slaver_ready,
  output logic             master_valid,
  output logic [DSIZE-1:0] master_data,
  input  logic             master_ready,
  output logic [CSIZE-1:0] count
);

  if (LAT == 0) begin : g_pass
    // Pure wiring: no state, so clock/rst/flush have nothing to act on.
    logic unused_pass;
    assign unused_pass  = ^{clock, rst, flush};
    assign master_valid = slaver_valid;
    assign master_data  = slaver_data;
    assign slaver_ready = master_ready;
    assign count        = '0;
  end else begin : g_pipe
    logic [LAT-1:0]   v_q, v_d;
    logic [LAT-1:0]   adv;
    logic [LAT-1:0]   src_v;
    logic [DSIZE-1:0] d_q   [LAT];
    logic [DSIZE-1:0] src_d [LAT];
    logic [CSIZE-1:0] count_q, count_d;
    logic             in_hs, out_hs;

    // Source of each stage: slaver for stage 0, previous stage otherwise.
    always_comb begin
      src_v[0] = slaver_valid;
      src_d[0] = slaver_data;
      for (int k = 1; k < int'(LAT); k++) begin
        src_v[k] = v_q[k-1];
        src_d[k] = d_q[k-1];
      end
    end

    // Per-stage advance: a global enable in lockstep, a ripple from the output in elastic mode.
    always_comb begin
      adv = '0;
      if (MODE == 0) begin
        adv = {LAT{master_ready}};
      end else begin
        adv[LAT-1] = ~v_q[LAT-1] | master_ready;
        for (int k = int'(LAT) - 2; k >= 0; k--) begin
          adv[k] = ~v_q[k] | adv[k+1];
        end
      end
    end

    assign in_hs  = slaver_valid & adv[0];
    assign out_hs = v_q[LAT-1] & master_ready;

    // Next stage valids and occupancy; flush wins over any load.
    always_comb begin
      v_d = v_q;
      for (int k = 0; k < int'(LAT); k++) begin
        if (adv[k]) v_d[k] = src_v[k];
      end
      count_d = count_q;
      if (in_hs && !out_hs) begin
        count_d = count_q + CSIZE'(1);
      end else if (!in_hs && out_hs) begin
        count_d = count_q - CSIZE'(1);
      end
      if (flush) begin
        v_d     = '0;
        count_d = '0;
      end
    end

    // Valid bits and count; reset beats flush.
    always_ff @(posedge clock) begin
      if (rst) begin
        v_q     <= '0;
        count_q <= '0;
      end else begin
        v_q     <= v_d;
        count_q <= count_d;
      end
    end

    // Data registers are not reset and only load real beats.
    always_ff @(posedge clock) begin
      for (int k = 0; k < int'(LAT); k++) begin
        if (adv[k] && src_v[k]) d_q[k] <= src_d[k];
      end
    end

    assign slaver_ready = adv[0];
    assign master_valid = v_q[LAT-1];
    assign master_data  = d_q[LAT-1];
    assign count        = count_q;
  end

endmodule

// File: tb/tb_data_c_pipe_latency_flex.sv
// Bench for data_c_pipe_latency_flex.
// Three registered instances share one stimulus set:
//   - lockstep with LAT=4
//   - elastic with LAT=4
//   - elastic with LAT=3
// Each row of the table checks one chosen instance.
// Every instance keeps its own order scoreboard.
// A LAT=0 instance is exercised separately with random traffic.
module tb_data_c_pipe_latency_flex;
  localparam int unsigned DW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, flush = 1'b0, sv = 1'b0, mr = 1'b1;
  logic [DW-1:0] sd = '0;

  logic r0, r1, r2, v0, v1, v2;
  logic [DW-1:0] d0, d1, d2;
  logic [2:0] c0, c1;
  logic [1:0] c2;

  logic z_sv = 1'b0, z_mr = 1'b0, z_fl = 1'b0, z_sr, z_mv;
  logic [DW-1:0] z_sd = '0, z_md;
  logic [0:0] z_c;

  data_c_pipe_latency_flex #(.LAT(4), .DSIZE(DW), .MODE(0)) u_lock (
    .clock(clk), .rst(rst), .flush(flush), .slaver_valid(sv), .slaver_data(sd),
    .slaver_ready(r0), .master_valid(v0), .master_data(d0), .master_ready(mr), .count(c0));
  data_c_pipe_latency_flex #(.LAT(4), .DSIZE(DW), .MODE(1)) u_elas (
    .clock(clk), .rst(rst), .flush(flush), .slaver_valid(sv), .slaver_data(sd),
    .slaver_ready(r1), .master_valid(v1), .master_data(d1), .master_ready(mr), .count(c1));
  data_c_pipe_latency_flex #(.LAT(3), .DSIZE(DW), .MODE(1)) u_el3 (
    .clock(clk), .rst(rst), .flush(flush), .slaver_valid(sv), .slaver_data(sd),
    .slaver_ready(r2), .master_valid(v2), .master_data(d2), .master_ready(mr), .count(c2));
  data_c_pipe_latency_flex #(.LAT(0), .DSIZE(DW), .MODE(1)) u_pass (
    .clock(clk), .rst(rst), .flush(z_fl), .slaver_valid(z_sv), .slaver_data(z_sd),
    .slaver_ready(z_sr), .master_valid(z_mv), .master_data(z_md), .master_ready(z_mr),
    .count(z_c));

  typedef struct {
    int          tid;
    int          inst;
    logic        sv;
    logic [DW-1:0] sd;
    logic        mr;
    logic        fl;
    logic        rs;
    logic        ev;
    logic [DW-1:0] ed;
    int          ec;
    logic        esr;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] sb0[$], sb1[$], sb2[$];
  int            out1, out2;
  int            n_run = 0, n_fail = 0;

  function automatic vec_t mk(int tid, int inst, bit s_v, int s_d, bit m_r, bit fl, bit rs,
                              bit e_v, int e_d, int e_c, bit e_sr);
    vec_t r;
    r.tid = tid; r.inst = inst; r.sv = s_v; r.sd = DW'(s_d); r.mr = m_r; r.fl = fl;
    r.rs = rs; r.ev = e_v; r.ed = DW'(e_d); r.ec = e_c; r.esr = e_sr;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(string name, logic [DW-1:0] act);
    n_run++;
    n_fail++;
    $display("FAIL %s: got output 0x%0h, want no output", name, act);
  endtask

  // Called once per cycle at the negedge: pop on master handshakes, push on slaver ones.
  task automatic sb_step();
    if (v0 && mr) begin
      if (sb0.size() == 0) unexpected("sb_lock", d0);
      else chk("sb_lock", 32'(d0), 32'(sb0.pop_front()));
    end
    if (v1 && mr) begin
      out1++;
      if (sb1.size() == 0) unexpected("sb_elas", d1);
      else chk("sb_elas", 32'(d1), 32'(sb1.pop_front()));
    end
    if (v2 && mr) begin
      out2++;
      if (sb2.size() == 0) unexpected("sb_el3", d2);
      else chk("sb_el3", 32'(d2), 32'(sb2.pop_front()));
    end
    if (rst || flush) begin
      sb0.delete(); sb1.delete(); sb2.delete();
    end else begin
      if (sv && r0) sb0.push_back(sd);
      if (sv && r1) sb1.push_back(sd);
      if (sv && r2) sb2.push_back(sd);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; sv = 1'b0; sd = '0; flush = 1'b0; mr = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb0.delete(); sb1.delete(); sb2.delete();
    out1 = 0; out2 = 0;
  endtask

  task automatic apply(vec_t r, int idx);
    logic av, ar;
    logic [DW-1:0] ad;
    int ac;
    string tag;
    @(posedge clk); #1;
    sv = r.sv; sd = r.sd; mr = r.mr; flush = r.fl; rst = r.rs;
    @(negedge clk);
    case (r.inst)
      0:       begin av = v0; ad = d0; ac = int'(c0); ar = r0; end
      1:       begin av = v1; ad = d1; ac = int'(c1); ar = r1; end
      default: begin av = v2; ad = d2; ac = int'(c2); ar = r2; end
    endcase
    tag = $sformatf("t%0d_row%0d", r.tid, idx);
    chk({tag, ".master_valid"}, 32'(av), 32'(r.ev));
    if (r.ev) chk({tag, ".master_data"}, 32'(ad), 32'(r.ed));
    chk({tag, ".count"}, 32'(ac), 32'(r.ec));
    chk({tag, ".slaver_ready"}, 32'(ar), 32'(r.esr));
    sb_step();
  endtask

  initial begin
    int prev;
    //                tid inst sv  sd    mr fl rs  ev  ed    ec sr
    // T1: lockstep, beats 0x01..0x05 back to back
    tbl.push_back(mk(1, 0, 1, 'h01, 1, 0, 0, 0, 0,    0, 1));
    tbl.push_back(mk(1, 0, 1, 'h02, 1, 0, 0, 0, 0,    1, 1));
    tbl.push_back(mk(1, 0, 1, 'h03, 1, 0, 0, 0, 0,    2, 1));
    tbl.push_back(mk(1, 0, 1, 'h04, 1, 0, 0, 0, 0,    3, 1));
    tbl.push_back(mk(1, 0, 1, 'h05, 1, 0, 0, 1, 'h01, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0,    1, 0, 0, 1, 'h02, 4, 1));
    tbl.push_back(mk(1, 0, 0, 0,    1, 0, 0, 1, 'h03, 3, 1));
    tbl.push_back(mk(1, 0, 0, 0,    1, 0, 0, 1, 'h04, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0,    1, 0, 0, 1, 'h05, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0,    1, 0, 0, 0, 0,    0, 1));
    // T2: lockstep, bubble 1,0,1 with a 3-cycle freeze
    tbl.push_back(mk(2, 0, 1, 'h11, 1, 0, 0, 0, 0,    0, 1));
    tbl.push_back(mk(2, 0, 0, 0,    1, 0, 0, 0, 0,    1, 1));
    tbl.push_back(mk(2, 0, 1, 'h13, 1, 0, 0, 0, 0,    1, 1));
    tbl.push_back(mk(2, 0, 0, 0,    1, 0, 0, 0, 0,    2, 1));
    tbl.push_back(mk(2, 0, 0, 0,    0, 0, 0, 1, 'h11, 2, 0));
    tbl.push_back(mk(2, 0, 0, 0,    0, 0, 0, 1, 'h11, 2, 0));
    tbl.push_back(mk(2, 0, 0, 0,    0, 0, 0, 1, 'h11, 2, 0));
    tbl.push_back(mk(2, 0, 0, 0,    1, 0, 0, 1, 'h11, 2, 1));
    tbl.push_back(mk(2, 0, 0, 0,    1, 0, 0, 0, 0,    1, 1));
    tbl.push_back(mk(2, 0, 0, 0,    1, 0, 0, 1, 'h13, 1, 1));
    tbl.push_back(mk(2, 0, 0, 0,    1, 0, 0, 0, 0,    0, 1));
    // T3: elastic LAT=4, 0xAA then 0xB0.. under backpressure
    tbl.push_back(mk(3, 1, 1, 'hAA, 0, 0, 0, 0, 0,    0, 1));
    tbl.push_back(mk(3, 1, 1, 'hB0, 0, 0, 0, 0, 0,    1, 1));
    tbl.push_back(mk(3, 1, 1, 'hB1, 0, 0, 0, 0, 0,    2, 1));
    tbl.push_back(mk(3, 1, 1, 'hB2, 0, 0, 0, 0, 0,    3, 1));
    tbl.push_back(mk(3, 1, 1, 'hB3, 0, 0, 0, 1, 'hAA, 4, 0));
    tbl.push_back(mk(3, 1, 1, 'hB3, 0, 0, 0, 1, 'hAA, 4, 0));
    tbl.push_back(mk(3, 1, 1, 'hB3, 0, 0, 0, 1, 'hAA, 4, 0));
    tbl.push_back(mk(3, 1, 1, 'hB3, 1, 0, 0, 1, 'hAA, 4, 1));
    tbl.push_back(mk(3, 1, 0, 0,    1, 0, 0, 1, 'hB0, 4, 1));
    tbl.push_back(mk(3, 1, 0, 0,    1, 0, 0, 1, 'hB1, 3, 1));
    tbl.push_back(mk(3, 1, 0, 0,    1, 0, 0, 1, 'hB2, 2, 1));
    tbl.push_back(mk(3, 1, 0, 0,    1, 0, 0, 1, 'hB3, 1, 1));
    tbl.push_back(mk(3, 1, 0, 0,    1, 0, 0, 0, 0,    0, 1));
    // T4: elastic LAT=3, flush at count=3 while 0x55 is accepted
    tbl.push_back(mk(4, 2, 1, 'h21, 0, 0, 0, 0, 0,    0, 1));
    tbl.push_back(mk(4, 2, 1, 'h22, 0, 0, 0, 0, 0,    1, 1));
    tbl.push_back(mk(4, 2, 1, 'h23, 0, 0, 0, 0, 0,    2, 1));
    tbl.push_back(mk(4, 2, 1, 'h55, 1, 1, 0, 1, 'h21, 3, 1));
    tbl.push_back(mk(4, 2, 0, 0,    1, 0, 0, 0, 0,    0, 1));
    tbl.push_back(mk(4, 2, 0, 0,    1, 0, 0, 0, 0,    0, 1));
    tbl.push_back(mk(4, 2, 0, 0,    1, 0, 0, 0, 0,    0, 1));
    tbl.push_back(mk(4, 2, 0, 0,    1, 0, 0, 0, 0,    0, 1));
    // T5/T6: reset mid-stream at count=2, then a fresh beat, lockstep then elastic
    for (int t = 5; t <= 6; t++) begin
      tbl.push_back(mk(t, t - 5, 1, 'h31, 1, 0, 0, 0, 0,    0, 1));
      tbl.push_back(mk(t, t - 5, 1, 'h32, 1, 0, 0, 0, 0,    1, 1));
      tbl.push_back(mk(t, t - 5, 0, 0,    1, 0, 1, 0, 0,    2, 1));
      tbl.push_back(mk(t, t - 5, 1, 'h41, 1, 0, 0, 0, 0,    0, 1));
      tbl.push_back(mk(t, t - 5, 0, 0,    1, 0, 0, 0, 0,    1, 1));
      tbl.push_back(mk(t, t - 5, 0, 0,    1, 0, 0, 0, 0,    1, 1));
      tbl.push_back(mk(t, t - 5, 0, 0,    1, 0, 0, 0, 0,    1, 1));
      tbl.push_back(mk(t, t - 5, 0, 0,    1, 0, 0, 1, 'h41, 1, 1));
      tbl.push_back(mk(t, t - 5, 0, 0,    1, 0, 0, 0, 0,    0, 1));
    end

    prev = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].tid != prev) begin
        if (prev == 3) begin
          chk("elastic_drain_outputs", 32'(out1), 32'd5);
          chk("elastic_sb_empty", 32'(sb1.size()), 32'd0);
        end
        if (prev == 4) chk("flush_outputs", 32'(out2), 32'd1);
        do_reset();
        prev = tbl[i].tid;
      end
      apply(tbl[i], i);
    end

    // Pass-through instance: combinational equality, count stays zero.
    @(posedge clk); #1;
    sv = 1'b0; flush = 1'b0; mr = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      z_sv = 1'($urandom_range(0, 1));
      z_mr = 1'($urandom_range(0, 1));
      z_fl = 1'($urandom_range(0, 1));
      z_sd = DW'($urandom);
      #1;
      chk("lat0_passthru", 32'({z_mv, z_md, z_sr, z_c}), 32'({z_sv, z_sd, z_mr, 1'b0}));
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/data_c_pipe_latency_flex.md
Name: data_c_pipe_latency_flex

Overview:
- Parametrised fixed-latency valid/ready data pipeline for the data_c stream family, with LAT register stages between upstream slaver and downstream master.
- Two stall modes:
  - Lockstep: the whole pipe freezes on downstream backpressure, for legacy timing-matched paths.
  - Elastic: bubbles are squeezed out under backpressure.
- Adds synchronous flush and an occupancy count. Used to balance latency against parallel compute paths.

Parameters:
- LAT, 4, number of register stages; legal 0..64; LAT=0 means combinational pass-through.
- DSIZE, 18, data width in bits.
- MODE, 0, 0 = lockstep stall, 1 = elastic (bubble-collapsing) stall.
- CSIZE, $clog2(LAT+1), width of the occupancy count, derived, not to be overridden.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stage valids; data is don't-care.
- slaver_valid  in  1  upstream valid.
- slaver_data  in  DSIZE  upstream data.
- slaver_ready  out  1  upstream ready.
- master_valid  out  1  downstream valid, equals stage[LAT-1] valid.
- master_data  out  DSIZE  downstream data, equals stage[LAT-1] data.
- master_ready  in  1  downstream ready.
- count  out  CSIZE  number of stages currently holding valid data.

Behaviour:
- Reset: at a clock edge with rst=1, all stage valids go to 0.
  - master_valid=0 and count=0 from the next cycle.
  - Stage data registers are not reset.
  - slaver_ready follows its combinational equation; in lockstep it still equals master_ready.
  - rst mid-stream discards every in-flight beat; nothing is emitted afterwards.
- Stage k, for k=0..LAT-1, holds a valid bit v[k] and a data register d[k]. Stage 0 loads from slaver; stage k loads from stage k-1.
- MODE=0 (lockstep):
  - adv = master_ready; slaver_ready = master_ready.
  - When adv=1, every stage shifts: v[0]<=slaver_valid, v[k]<=v[k-1], and data shifts with it.
  - When adv=0, all stages hold.
  - Bubbles are preserved: input-to-output spacing is exact.
  - An input beat appears at the output after exactly LAT advancing cycles.
- MODE=1 (elastic):
  - adv[LAT-1] = ~v[LAT-1] | master_ready.
  - adv[k] = ~v[k] | adv[k+1], for k<LAT-1.
  - slaver_ready = adv[0].
  - Stage k loads from its source when adv[k]=1. v[k] takes the source valid (slaver_valid for k=0).
  - Data registers load only when the source valid is 1, which saves power.
  - Under sustained master_ready=0 the pipe fills to LAT beats and then deasserts slaver_ready.
  - With no backpressure, latency is LAT cycles and throughput is 1 beat per cycle.
- A handshake is valid&ready on either side. A beat offered with slaver_valid=1 and slaver_ready=0 is not taken; upstream holds it.
- flush:
  - Takes effect at the clock edge and has priority over loads. All v[k]<=0 and count<=0.
  - A beat presented at the flush edge is consumed and dropped: slaver_ready keeps its normal value.
  - rst has priority over flush.
- count:
  - Registered. Incremented on a slaver handshake, decremented on a master handshake; both together leave it unchanged.
  - Lockstep mode counts valid stages, so its maximum is LAT.
  - Must always equal popcount(v).
- LAT=0:
  - master_valid=slaver_valid, master_data=slaver_data, slaver_ready=master_ready.
  - count is tied to 0; flush has no effect.
  - No registers.
- LAT=1 in MODE=1 behaves as a single-entry pipe register with through-ready.

Test Plan:
- MODE=0, LAT=4, master_ready=1, beats 0x01..0x05 on consecutive cycles, starting at cycle 0 -> master_valid high cycles 4..8 with data 0x01..0x05; count peaks at 4.
- MODE=0, LAT=4, bubble pattern valid 1,0,1, then master_ready=0 for 3 cycles mid-stream -> output spacing 1,0,1 preserved; the whole pipe is frozen for exactly 3 cycles; slaver_ready equals master_ready every cycle.
- MODE=1, LAT=4, a single beat 0xAA then master_ready=0 held, with slaver_valid=1 streaming 0xB0.. -> pipe fills to count=4; slaver_ready drops when count=4; release master_ready -> output order 0xAA,0xB0,0xB1,0xB2 with no loss or duplication.
- MODE=1, LAT=3, flush pulsed with count=3 and slaver beat 0x55 offered on the same edge -> next cycle count=0 and master_valid=0; 0x55 is never emitted.
- Either mode, rst asserted for 1 cycle with count=2 -> next cycle master_valid=0 and count=0; a subsequent beat emerges after exactly LAT cycles.
- LAT=0 with random valid/ready for 1000 cycles -> outputs equal inputs combinationally; count=0 throughout.
